mem_mod_sel_seq: RTL

- Memory module select and access sequencer. It sits directly downstream of the memory module/sector select register stage.
- Consumes the active-low module selects (MZON/MTTN/MFFN/MSSN) and the active-low instruction/data sector-half selects (IMAN/IMBN, DMAN/DMBN).
- Runs one destructive-readout core access per start strobe: select, read, sense strobe, regenerate/write, done.
- Drives per-module enable and timing strobes to the memory drive/sense logic.

---
 rtl/mem_seq_pkg.sv | 23 ++
 rtl/mem_sel_decode.sv | 42 ++++
 rtl/mem_mod_sel_seq.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/mem_seq_pkg.sv
// mem_seq_pkg: shared definitions for the memory module select sequencer.
//   state_t       : sequencer FSM states
//   MOD0..MOD6    : bit positions of modules 0/2/4/6 in the one-hot enable
//   CNT_W         : width of the shared SEL/RD/WR down-counter
package mem_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_SEL  = 3'd1,
    S_RD   = 3'd2,
    S_SNS  = 3'd3,
    S_WR   = 3'd4,
    S_FIN  = 3'd5
  } state_t;

  localparam int MOD0  = 0;
  localparam int MOD2  = 1;
  localparam int MOD4  = 2;
  localparam int MOD6  = 3;

  localparam int CNT_W = 4;

endpackage

// File: rtl/mem_sel_decode.sv
// mem_sel_decode: combinational select check for one core access.
//   in  mzon/mttn/mffn/mssn : active-low module selects 0/2/4/6
//   in  iman/imbn           : active-low instruction half selects A/B
//   in  dman/dmbn           : active-low data half selects A/B
//   in  acc_data            : 1 = use data half pair, 0 = instruction pair
//   out mod_en[3:0]         : active-high module vector (one-hot when legal)
//   out side_a/side_b       : active-high half enables of the chosen pair
//   out legal               : exactly one module and at least one half selected
module mem_sel_decode
  import mem_seq_pkg::*;
(
  input  logic       mzon,
  input  logic       mttn,
  input  logic       mffn,
  input  logic       mssn,
  input  logic       iman,
  input  logic       imbn,
  input  logic       dman,
  input  logic       dmbn,
  input  logic       acc_data,
  output logic [3:0] mod_en,
  output logic       side_a,
  output logic       side_b,
  output logic       legal
);

  always_comb begin
    mod_en       = '0;
    mod_en[MOD0] = ~mzon;
    mod_en[MOD2] = ~mttn;
    mod_en[MOD4] = ~mffn;
    mod_en[MOD6] = ~mssn;
  end

  // Only the pair matching the access type is looked at; the other pair
  // may hold anything, including an illegal combination.
  assign side_a = acc_data ? ~dman : ~iman;
  assign side_b = acc_data ? ~dmbn : ~imbn;

  assign legal = $onehot(mod_en) && (side_a || side_b);

endmodule

// File: rtl/mem_mod_sel_seq.sv
// mem_mod_sel_seq: memory module select and destructive-readout access
// sequencer. One START runs SEL -> RD -> SNS -> WR -> FIN.
//   in  clk, reset (async, active high)
//   in  start            : access request pulse, sampled only in IDLE
//   in  acc_data         : 1 = data access (DMAN/DMBN), 0 = instruction
//   in  acc_write        : 1 = store (no sense strobe)
//   in  mzon..mssn       : active-low module selects 0/2/4/6
//   in  iman/imbn, dman/dmbn : active-low half selects
//   out mod_en[3:0]      : one-hot module enable, held through BUSY
//   out side_a, side_b   : latched half enables
//   out rd_stb, sense_stb, wr_stb : registered timing strobes
//   out busy, done, sel_err
// Optional build macro MEM_DUPLEX_CMP_EN adds par_ok_a/par_ok_b inputs
// and data_side_b/par_err outputs for duplex half comparison. Without it
// the sense path implicitly uses A when side_a is set, else B.
module mem_mod_sel_seq
  import mem_seq_pkg::*;
#(
  parameter int SEL_CYC = 1,
  parameter int RD_CYC  = 2,
  parameter int WR_CYC  = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       acc_data,
  input  logic       acc_write,
  input  logic       mzon,
  input  logic       mttn,
  input  logic       mffn,
  input  logic       mssn,
  input  logic       iman,
  input  logic       imbn,
  input  logic       dman,
  input  logic       dmbn,
`ifdef MEM_DUPLEX_CMP_EN
  input  logic       par_ok_a,
  input  logic       par_ok_b,
  output logic       data_side_b,
  output logic       par_err,
`endif
  output logic [3:0] mod_en,
  output logic       side_a,
  output logic       side_b,
  output logic       rd_stb,
  output logic       sense_stb,
  output logic       wr_stb,
  output logic       busy,
  output logic       done,
  output logic       sel_err
);

  // Counter reload values: a phase of N cycles counts N-1 down to 0.
  localparam logic [CNT_W-1:0] SEL_LD = CNT_W'(SEL_CYC - 1);
  localparam logic [CNT_W-1:0] RD_LD  = CNT_W'(RD_CYC - 1);
  localparam logic [CNT_W-1:0] WR_LD  = CNT_W'(WR_CYC - 1);

  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic             accept, reject;
  logic             wr_lat;

  logic [3:0]       dec_mod;
  logic             dec_a, dec_b, dec_legal;

  mem_sel_decode u_dec (
    .mzon     (mzon),
    .mttn     (mttn),
    .mffn     (mffn),
    .mssn     (mssn),
    .iman     (iman),
    .imbn     (imbn),
    .dman     (dman),
    .dmbn     (dmbn),
    .acc_data (acc_data),
    .mod_en   (dec_mod),
    .side_a   (dec_a),
    .side_b   (dec_b),
    .legal    (dec_legal)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    accept   = 1'b0;
    reject   = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          if (dec_legal) begin
            accept   = 1'b1;
            state_nx = S_SEL;
            cnt_nx   = SEL_LD;
          end else begin
            reject   = 1'b1;
          end
        end
      end
      S_SEL: begin
        if (cnt == '0) begin
          state_nx = S_RD;
          cnt_nx   = RD_LD;
        end else begin
          cnt_nx   = cnt - 1'b1;
        end
      end
      S_RD: begin
        if (cnt == '0) state_nx = S_SNS;
        else           cnt_nx   = cnt - 1'b1;
      end
      S_SNS: begin
        state_nx = S_WR;
        cnt_nx   = WR_LD;
      end
      S_WR: begin
        if (cnt == '0) state_nx = S_FIN;
        else           cnt_nx   = cnt - 1'b1;
      end
      S_FIN:   state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state so each strobe lines up
  // exactly with the cycle its state occupies.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mod_en    <= '0;
      side_a    <= 1'b0;
      side_b    <= 1'b0;
      wr_lat    <= 1'b0;
      rd_stb    <= 1'b0;
      sense_stb <= 1'b0;
      wr_stb    <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      sel_err   <= 1'b0;
    end else begin
      busy      <= (state_nx != S_IDLE);
      rd_stb    <= (state_nx == S_RD);
      sense_stb <= (state_nx == S_SNS) && !wr_lat;
      wr_stb    <= (state_nx == S_WR);
      done      <= (state_nx == S_FIN);
      sel_err   <= reject;
      if (accept) begin
        mod_en <= dec_mod;
        side_a <= dec_a;
        side_b <= dec_b;
        wr_lat <= acc_write;
      end else if (state == S_FIN) begin
        mod_en <= '0;
        side_a <= 1'b0;
        side_b <= 1'b0;
      end
    end
  end

`ifdef MEM_DUPLEX_CMP_EN
  logic pick_b, perr_calc, perr_lat;

  // Duplex prefers A and falls back to B; simplex is stuck with its half.
  always_comb begin
    pick_b    = 1'b0;
    perr_calc = 1'b0;
    if (side_a && side_b) begin
      pick_b    = !par_ok_a;
      perr_calc = !par_ok_a && !par_ok_b;
    end else if (side_a) begin
      pick_b    = 1'b0;
      perr_calc = !par_ok_a;
    end else begin
      pick_b    = 1'b1;
      perr_calc = !par_ok_b;
    end
    if (wr_lat) perr_calc = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_side_b <= 1'b0;
      perr_lat    <= 1'b0;
      par_err     <= 1'b0;
    end else begin
      if (accept) begin
        data_side_b <= 1'b0;
        perr_lat    <= 1'b0;
      end else if (state == S_SNS) begin
        data_side_b <= pick_b;
        perr_lat    <= perr_calc;
      end
      par_err <= (state_nx == S_FIN) && perr_lat;
    end
  end
`endif

endmodule
